mod_err_demod: RTL and testbench
================================

MOD_ERR_DEMOD -- requirements
Module: mod_err_demod

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: i_clk input 1, rising-edge clock for all state; i_rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL have i_en input 1: 1 = run modulation/demodulation; 0 = idle.
REQ-003 SHALL have i_adc input 14 signed: ADC sample, one per clock.
REQ-004 SHALL have i_freq_cnt input 16 unsigned: half-period N in clocks.
REQ-005 SHALL have i_wait_cnt input 16 unsigned: settling clocks W skipped after each modulation edge.
REQ-006 SHALL have i_polarity input 32: bit0 = 1 negates the error; bits 31:1 are ignored.
REQ-007 SHALL have i_err_offset input 32 signed: subtracted from the error.
REQ-008 SHALL have o_mod_out output 1: square-wave modulation level, 1 = high half.
REQ-009 SHALL have o_err output 32 signed: demodulated error that feeds the feedback step generator's error input.
REQ-010 SHALL have o_trig output 1: single-clock strobe that feeds the step generator's trigger and marks a new o_err.
REQ-011 SHALL have o_status output 2: current FSM state code.

Function
REQ-012 SHALL register i_adc once; every accumulated sample is the registered value, one clock of ADC latency.
REQ-013 SHALL implement FSM IDLE(0), HIGH(1), LOW(2), with a counter c counting 0..N-1 within each half.
REQ-014 SHALL latch N, W, polarity and offset in IDLE on the transition to HIGH, and at every HIGH entry from LOW; mid-period input changes SHALL have no effect.
REQ-015 SHALL treat the parameters as valid only when N>=2 and W<N; otherwise the FSM SHALL stay in IDLE, or return to IDLE at the next period boundary.
REQ-016 SHALL transition IDLE->HIGH when i_en=1 and the parameters are valid; sum_h and sum_l SHALL clear on entry to HIGH.
REQ-017 SHALL drive o_mod_out=1 in HIGH and 0 in LOW and IDLE.
REQ-018 SHALL, in HIGH, add the registered sample to sum_h when c>=W, and go HIGH->LOW at c=N-1.
REQ-019 SHALL, in LOW, add the registered sample to sum_l when c>=W, and go LOW->HIGH at c=N-1 (period boundary).
REQ-020 SHALL size sum_h and sum_l at 30 bits signed; no overflow is possible.
REQ-021 SHALL, at the period boundary, compute e = sum_h - sum_l (31 bits), negate e if polarity bit0 is set, then subtract the offset in 34-bit arithmetic.
REQ-022 SHALL saturate that result to [-2^31, 2^31-1] and register it into o_err on the clock after the boundary, with o_trig=1 on that same clock.
REQ-023 SHALL hold o_err between updates; o_trig SHALL be high for exactly one clock per completed period.
REQ-024 SHALL, when i_en falls mid-period, enter IDLE on the next clock, discard partial sums, emit no o_trig, and hold o_err.
REQ-025 SHALL, when i_en returns, start a fresh full period from HIGH with c=0.
REQ-026 SHALL give a period-boundary o_trig priority over a simultaneous i_en fall.

Reset
REQ-027 SHALL set all outputs on i_rst_n=0 to: o_mod_out=0, o_err=0, o_trig=0, o_status=0 (IDLE).
REQ-028 SHALL also clear on reset: sums, c, latched parameters (N=0, so invalid), and the ADC register.
REQ-029 SHALL, on reset mid-period, abandon the period with no o_trig.
REQ-030 SHALL, after reset release, wait in IDLE until i_en=1 with valid parameters.

Structure
REQ-031 SHALL place the FSM state codes, the ADC width (14) and the saturation limits in the shared fog package.
REQ-032 SHALL place the sum, polarity, offset and saturation step in one sub-module, err_sat_calc, which is combinational with a registered output.

Verification
REQ-033 SHALL cover: N=8, W=2, adc constant 100 -> o_trig every 16 clocks, o_err=0.
REQ-034 SHALL cover: N=8, W=2, adc driven as (o_mod_out ? 1000 : 0) -> o_err=6000; with polarity=1 -> -6000; with polarity=0 and offset=500 -> 5500.
REQ-035 SHALL cover: N=8, W=8 (invalid) with i_en=1 -> o_status=0, o_mod_out=0, no o_trig for 100 clocks.
REQ-036 SHALL cover: i_en dropped at c=3 of LOW -> no o_trig, o_err holds its last value; on re-enable, first o_trig arrives 16 clocks plus 1 later.
REQ-037 SHALL cover: N=65535, W=0, adc=8191 in high half and -8192 in low half, offset=-2^31 -> o_err=0x7FFFFFFF (saturated).
REQ-038 SHALL cover: i_freq_cnt changed from 8 to 4 mid-period -> current period completes at 16 clocks, the next period takes 8 clocks.

Source files
------------

// File: rtl/fog_pkg.sv
// Shared definitions for the modulation / error-demodulation block:
// FSM state codes, sample and accumulator widths, and saturation limits.
package fog_pkg;

  localparam int ADC_W = 14;
  localparam int SUM_W = 30;
  localparam int ERR_W = 32;

  // Limits held in the 34-bit pre-saturation domain and in the 32-bit result domain
  localparam logic signed [ERR_W+1:0] SAT_MAX = 34'sh0_7FFF_FFFF;
  localparam logic signed [ERR_W+1:0] SAT_MIN = 34'sh3_8000_0000;
  localparam logic signed [ERR_W-1:0] ERR_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [ERR_W-1:0] ERR_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/err_sat_calc.sv
// Period-end error computation: e = sum_h - sum_l, optional negation,
// offset subtraction in 34 bits, saturation to 32 bits, registered output
// together with a one-clock trigger strobe.
module err_sat_calc
  import fog_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic signed [SUM_W-1:0] sum_h,
  input  logic signed [SUM_W-1:0] sum_l,
  input  logic                    negate,
  input  logic signed [ERR_W-1:0] offset,
  output logic signed [ERR_W-1:0] err,
  output logic                    trig
);

  logic signed [SUM_W:0]   diff;
  logic signed [ERR_W+1:0] ext;
  logic signed [ERR_W+1:0] full;
  logic signed [ERR_W-1:0] sat;

  // Difference, polarity, offset and clamp; widths chosen so no step can wrap
  always_comb begin
    diff = {sum_h[SUM_W-1], sum_h} - {sum_l[SUM_W-1], sum_l};
    ext  = {{(ERR_W+1-SUM_W){diff[SUM_W]}}, diff};
    if (negate) begin
      ext = -ext;
    end
    full = ext - {{2{offset[ERR_W-1]}}, offset};
    if (full > SAT_MAX) begin
      sat = ERR_MAX;
    end else if (full < SAT_MIN) begin
      sat = ERR_MIN;
    end else begin
      sat = full[ERR_W-1:0];
    end
  end

  // Hold the error between period ends; strobe marks each fresh value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err  <= '0;
      trig <= 1'b0;
    end else begin
      trig <= load;
      if (load) begin
        err <= sat;
      end
    end
  end

endmodule

// File: rtl/mod_err_demod.sv
// Square-wave modulator with synchronous demodulation of the ADC stream.
// Each period is a HIGH half and a LOW half of N clocks; the first W clocks
// of each half are skipped for settling, the rest are accumulated.
//
// state | meaning
// IDLE  | not running, sums and counter cleared, mod output low
// HIGH  | mod output high, accumulating into sum_h
// LOW   | mod output low, accumulating into sum_l; last clock is the period end
module mod_err_demod
  import fog_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic signed [ADC_W-1:0] i_adc,
  input  logic [15:0]             i_freq_cnt,
  input  logic [15:0]             i_wait_cnt,
  input  logic [31:0]             i_polarity,
  input  logic signed [ERR_W-1:0] i_err_offset,
  output logic                    o_mod_out,
  output logic signed [ERR_W-1:0] o_err,
  output logic                    o_trig,
  output logic [1:0]              o_status
);

  state_t                  state, state_nxt;
  logic [15:0]             c, c_nxt, n_q, w_q;
  logic                    pol_q;
  logic signed [ERR_W-1:0] off_q;
  logic signed [ADC_W-1:0] adc_q;
  logic signed [SUM_W-1:0] sum_h, sum_l, sum_h_nxt, sum_l_nxt, sum_l_acc, adc_ext;
  logic                    valid_in, last, acc, boundary, load_params;
  logic                    unused_pol;

  assign unused_pol = ^i_polarity[31:1];
  assign valid_in   = (i_freq_cnt >= 16'd2) && (i_wait_cnt < i_freq_cnt);
  assign last       = (c == n_q - 16'd1);
  assign acc        = (c >= w_q);
  assign adc_ext    = {{(SUM_W-ADC_W){adc_q[ADC_W-1]}}, adc_q};
  assign sum_l_acc  = acc ? (sum_l + adc_ext) : sum_l;
  assign o_mod_out  = (state == ST_HIGH);
  assign o_status   = state;

  // Next state, half counter and accumulators; the period end wins over an enable drop
  always_comb begin
    state_nxt   = state;
    c_nxt       = c;
    sum_h_nxt   = sum_h;
    sum_l_nxt   = sum_l;
    load_params = 1'b0;
    boundary    = 1'b0;
    case (state)
      ST_IDLE: begin
        c_nxt     = '0;
        sum_h_nxt = '0;
        sum_l_nxt = '0;
        if (i_en && valid_in) begin
          state_nxt   = ST_HIGH;
          load_params = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!i_en) begin
          state_nxt = ST_IDLE;
          c_nxt     = '0;
          sum_h_nxt = '0;
          sum_l_nxt = '0;
        end else begin
          if (acc) begin
            sum_h_nxt = sum_h + adc_ext;
          end
          if (last) begin
            state_nxt = ST_LOW;
            c_nxt     = '0;
          end else begin
            c_nxt = c + 16'd1;
          end
        end
      end
      ST_LOW: begin
        if (last) begin
          boundary  = 1'b1;
          c_nxt     = '0;
          sum_h_nxt = '0;
          sum_l_nxt = '0;
          if (i_en && valid_in) begin
            state_nxt   = ST_HIGH;
            load_params = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (!i_en) begin
          state_nxt = ST_IDLE;
          c_nxt     = '0;
          sum_h_nxt = '0;
          sum_l_nxt = '0;
        end else begin
          sum_l_nxt = sum_l_acc;
          c_nxt     = c + 16'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter, sums, sample register and per-period parameter latch
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      c     <= '0;
      sum_h <= '0;
      sum_l <= '0;
      adc_q <= '0;
      n_q   <= '0;
      w_q   <= '0;
      pol_q <= 1'b0;
      off_q <= '0;
    end else begin
      state <= state_nxt;
      c     <= c_nxt;
      sum_h <= sum_h_nxt;
      sum_l <= sum_l_nxt;
      adc_q <= i_adc;
      if (load_params) begin
        n_q   <= i_freq_cnt;
        w_q   <= i_wait_cnt;
        pol_q <= i_polarity[0];
        off_q <= i_err_offset;
      end
    end
  end

  // Polarity and offset are those latched for the period that is ending
  err_sat_calc u_calc (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .load   (boundary),
    .sum_h  (sum_h),
    .sum_l  (sum_l_acc),
    .negate (pol_q),
    .offset (off_q),
    .err    (o_err),
    .trig   (o_trig)
  );

endmodule

// File: tb/tb_mod_err_demod.sv
// Scoreboard bench for mod_err_demod: stimulus pushes expected (error, gap)
// pairs, an independent monitor pops one per o_trig and compares.
module tb_mod_err_demod;

  typedef struct {
    logic signed [31:0] err;
    int                 gap;
    bit                 from_en;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [13:0] adc;
  logic [15:0]        freq;
  logic [15:0]        wt;
  logic [31:0]        pol;
  logic signed [31:0] off;
  logic               mod_out;
  logic signed [31:0] err;
  logic               trig;
  logic [1:0]         status;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   en_cyc = 0;
  int   last_trig = 0;
  int   adc_mode = 0;
  int   bad_cycles;
  exp_t q[$];
  exp_t mon_e;
  int   mon_gap;

  mod_err_demod dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_adc        (adc),
    .i_freq_cnt   (freq),
    .i_wait_cnt   (wt),
    .i_polarity   (pol),
    .i_err_offset (off),
    .o_mod_out    (mod_out),
    .o_err        (err),
    .o_trig       (trig),
    .o_status     (status)
  );

  always #5 clk = ~clk;

  // ADC stimulus: constant, or following the modulation level
  always @(negedge clk) begin
    case (adc_mode)
      0:       adc = 14'sd100;
      1:       adc = mod_out ? 14'sd1000 : 14'sd0;
      default: adc = mod_out ? 14'sd8191 : 14'sh2000;
    endcase
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: one expectation consumed per trigger strobe
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (trig === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_trig: o_trig=1 at cycle %0d with o_err=%0d, expected no trigger", cyc, err);
      end else begin
        mon_e = q.pop_front();
        chk("trig_err", err, mon_e.err);
        if (mon_e.gap != 0) begin
          mon_gap = cyc - (mon_e.from_en ? en_cyc : last_trig);
          chk("trig_gap", mon_gap, mon_e.gap);
        end
      end
      last_trig = cyc;
    end
  end

  task automatic push(input logic signed [31:0] e, input int gap, input bit from_en);
    exp_t x;
    x.err = e;
    x.gap = gap;
    x.from_en = from_en;
    q.push_back(x);
  endtask

  task automatic setup(input int n, input int w, input bit p,
                       input logic signed [31:0] o, input int mode);
    en       = 1'b0;
    freq     = 16'(n);
    wt       = 16'(w);
    pol      = {31'h7FFF_FFFF, p};
    off      = o;
    adc_mode = mode;
    repeat (2) @(negedge clk);
  endtask

  task automatic go();
    en_cyc = cyc;
    en     = 1'b1;
  endtask

  task automatic stop();
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d triggers still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    freq  = 16'd8;
    wt    = 16'd2;
    pol   = '0;
    off   = '0;
    repeat (3) @(negedge clk);
    chk("rst_mod_out", 32'(mod_out), 0);
    chk("rst_err", err, 0);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_status", 32'(status), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_release", 32'(status), 0);

    // constant input: halves cancel, trigger every 16 clocks
    setup(8, 2, 1'b0, 0, 0);
    push(0, 17, 1'b1); push(0, 16, 1'b0); push(0, 16, 1'b0);
    go(); drain(200); stop();

    // modulated input: 6 settled samples of 1000 in the high half
    setup(8, 2, 1'b0, 0, 1);
    push(6000, 17, 1'b1); push(6000, 16, 1'b0);
    go(); drain(200); stop();

    setup(8, 2, 1'b1, 0, 1);
    push(-6000, 17, 1'b1);
    go(); drain(200); stop();

    setup(8, 2, 1'b0, 500, 1);
    push(5500, 17, 1'b1);
    go(); drain(200); stop();

    // -6000 - (2^31-1) underflows to the negative limit
    setup(8, 2, 1'b1, 32'sh7FFF_FFFF, 1);
    push(32'sh8000_0000, 17, 1'b1);
    go(); drain(200); stop();

    // large positive error minus -2^31 clamps to the positive limit
    setup(1000, 0, 1'b0, 32'sh8000_0000, 2);
    push(32'sh7FFF_FFFF, 2001, 1'b1);
    go(); drain(3000); stop();

    // W == N is invalid: stays idle, no triggers
    setup(8, 8, 1'b0, 0, 1);
    bad_cycles = 0;
    en = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (status !== 2'd0 || mod_out !== 1'b0) bad_cycles++;
    end
    chk("invalid_idle_cycles", bad_cycles, 0);
    stop();

    // enable dropped at c=3 of LOW: no trigger, error held, fresh restart
    setup(8, 2, 1'b0, 0, 1);
    push(6000, 17, 1'b1);
    go(); drain(200);
    repeat (11) @(negedge clk);
    chk("drop_pos_status", 32'(status), 2);
    en = 1'b0;
    @(negedge clk);
    chk("drop_status", 32'(status), 0);
    chk("drop_err_hold", err, 6000);
    repeat (20) @(negedge clk);
    chk("drop_err_hold_later", err, 6000);
    off = 500;
    push(5500, 17, 1'b1);
    go(); drain(200); stop();

    // N changed 8 -> 4 mid-period: current period unaffected, next one is 8 clocks
    setup(8, 2, 1'b0, 0, 1);
    push(6000, 17, 1'b1); push(2000, 8, 1'b0);
    go();
    repeat (5) @(negedge clk);
    freq = 16'd4;
    drain(200); stop();

    // reset mid-period abandons the period and clears the error
    setup(8, 2, 1'b0, 0, 1);
    go();
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_mod_out", 32'(mod_out), 0);
    chk("midrst_err", err, 0);
    chk("midrst_status", 32'(status), 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_status", 32'(status), 0);
    chk("post_rst_err", err, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
